// File: rtl/sensor_pkt_pkg.sv
// Shared definitions for the sensor packetizer: packet header byte, TX state
// encoding and the sample-index width helper.
package sensor_pkt_pkg;

  localparam logic [7:0] PKT_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ID,
    SEQ,
    DATA,
    CSUM
  } tx_state_t;

  function automatic int idx_width(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/sensor_sample_timer.sv
// Paces the sensor: one-cycle sensor_en every SAMPLE_PERIOD cycles while run is
// high, and a capture strobe SENSOR_LATENCY cycles after each pulse.
module sensor_sample_timer #(
  parameter int SAMPLE_PERIOD  = 100,
  parameter int SENSOR_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sensor_en,
  output logic capture
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0]             cnt;
  logic [SENSOR_LATENCY-1:0] pipe;

  // Gating with run drops a strobe that lands in the cycle run falls.
  assign sensor_en = run && (cnt == LAST);
  assign capture   = run && pipe[SENSOR_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt  <= '0;
      pipe <= '0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      pipe <= (pipe << 1) | SENSOR_LATENCY'(sensor_en);
    end
  end

endmodule

// File: rtl/sensor_packetizer.sv
// Collects sensor readings into framed packets and streams them byte-wise over
// valid/ready. Define PKT_CHECKSUM_EN to append an XOR checksum byte.
module sensor_packetizer #(
  parameter int          SAMPLE_PERIOD   = 100,
  parameter int          SENSOR_LATENCY  = 1,
  parameter int          SAMPLES_PER_PKT = 4,
  parameter logic [7:0]  NODE_ID         = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       sensor_en,
  input  logic [7:0] sensor_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  import sensor_pkt_pkg::*;

  localparam int N     = SAMPLES_PER_PKT;
  localparam int IW    = idx_width(N);
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_DIDX = AW'(N - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  // Handshake: a byte transfers in any cycle with tx_valid & tx_ready; while
  // tx_valid is high and tx_ready low, tx_data and tx_last do not change.
  logic          capture;
  logic [IW-1:0] idx;
  logic [AW-1:0] didx;
  logic [7:0]    seq;
  logic [7:0]    pkt_seq;
  logic [7:0]    collect_buf [DEPTH];
  logic [7:0]    tx_buf      [DEPTH];
  logic [7:0]    commit_data [DEPTH];
  tx_state_t     state, state_next;
  logic          hs, last_hs, tx_free, commit_req, commit_ok;

  sensor_sample_timer #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .SENSOR_LATENCY(SENSOR_LATENCY)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .sensor_en(sensor_en),
    .capture  (capture)
  );

  assign hs         = tx_valid && tx_ready;
  assign last_hs    = hs && tx_last;
  assign tx_free    = (state == IDLE) || last_hs;
  assign commit_req = capture && (idx == LAST_IDX);
  assign commit_ok  = commit_req && tx_free;
  assign busy       = (state != IDLE);

  // The final reading is folded in directly so the packet commits on its capture.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) commit_data[i] = collect_buf[i];
    commit_data[LAST_DIDX] = sensor_data;
  end

`ifdef PKT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = PKT_HDR ^ NODE_ID ^ pkt_seq;
    for (int i = 0; i < N; i++) csum = csum ^ tx_buf[AW'(i)];
  end
`endif

  always_comb begin
    tx_valid = (state != IDLE);
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    case (state)
      HDR:  tx_data = PKT_HDR;
      ID:   tx_data = NODE_ID;
      SEQ:  tx_data = pkt_seq;
      DATA: begin
        tx_data = tx_buf[didx];
`ifndef PKT_CHECKSUM_EN
        tx_last = (didx == LAST_DIDX);
`endif
      end
`ifdef PKT_CHECKSUM_EN
      CSUM: begin
        tx_data = csum;
        tx_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (commit_ok) state_next = HDR;
      HDR:  if (hs) state_next = ID;
      ID:   if (hs) state_next = SEQ;
      SEQ:  if (hs) state_next = DATA;
      DATA: if (hs && didx == LAST_DIDX) begin
`ifdef PKT_CHECKSUM_EN
        state_next = CSUM;
`else
        state_next = commit_ok ? HDR : IDLE;
`endif
      end
      CSUM: if (hs) state_next = commit_ok ? HDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      didx     <= '0;
      seq      <= '0;
      pkt_seq  <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        collect_buf[i] <= '0;
        tx_buf[i]      <= '0;
      end
    end else begin
      state <= state_next;

      if (state != DATA) didx <= '0;
      else if (hs)       didx <= didx + 1'b1;

      if (!run) begin
        idx <= '0;
      end else if (capture) begin
        collect_buf[idx[AW-1:0]] <= sensor_data;
        idx <= commit_req ? '0 : idx + 1'b1;
      end

      // Dropped packets leave seq untouched so the receiver sees no gap in numbering.
      if (commit_ok) begin
        for (int i = 0; i < DEPTH; i++) tx_buf[i] <= commit_data[i];
        pkt_seq <= seq;
        seq     <= seq + 1'b1;
      end else if (commit_req && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
